// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and types for the instruction-SRAM responder.
// Holds the FSM state type, the reset-PC/base address and the read latency.
package inst_sram_responder_pkg;

    // Word 0 of the SRAM sits at the core's reset PC.
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    // rdata is registered: valid one edge after the request.
    localparam logic RDATA_LAT = 1'b1;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/inst_sram_responder_if.sv
// Bus bundles for the responder: the CPU inst-SRAM port and the boot stream.
// master = the driving side (fetch stage / boot source), slave = responder.
interface inst_sram_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata
    );
    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

interface boot_ld_if;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready
    );
    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/inst_sram_responder_sram_bank.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 32, byte-lane writes, read-first.
// Ports: clk/reset, en, we[3:0], idx, wdata, clr (forces rdata to 0), rdata.
module sram_bank #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    input  logic                  clr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q, rdata_d;

    // clr wins over a read; idle cycles hold the last word.
    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (en) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // No reset on the array: contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram_responder.sv
// Inst-SRAM responder with boot loader: fills memory from ld_* then serves CPU.
// Ports: clk, reset, cpu (inst_sram_if), ld (boot_ld_if), boot_done, oor_err, ld_ovf.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = RESET_PC,
    parameter bit          BOOT_LOAD  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    inst_sram_if.slave cpu,
    boot_ld_if.slave   ld,
    output logic       boot_done,
    output logic       oor_err,
    output logic       ld_ovf
);

    localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  oor_err_q, oor_err_d;
    logic                  ld_ovf_q, ld_ovf_d;

    logic [31:0]           off;
    logic                  in_range;
    logic                  in_load;
    logic                  ld_fire;
    logic                  cpu_req;
    logic                  cnt_max;
    logic                  unused_addr_lsb;

    logic                  b_en;
    logic [3:0]            b_we;
    logic [DEPTH_LOG2-1:0] b_idx;
    logic [31:0]           b_wdata;
    logic                  b_clr;

    // Wrapping subtract folds "below base" into a huge offset.
    assign off             = cpu.inst_sram_addr - BASE_ADDR;
    assign in_range        = {1'b0, off} < WIN_BYTES;
    assign unused_addr_lsb = ^off[1:0];

    assign in_load  = (state_q == LOAD);
    assign ld_fire  = in_load & ld.ld_valid;
    assign cpu_req  = ~in_load & cpu.inst_sram_en;
    assign cnt_max  = (cnt_q == '1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oor_err_d = oor_err_q | (cpu_req & ~in_range);
        ld_ovf_d  = ld_ovf_q;
        if (ld_fire) begin
            if (!cnt_max) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (ld.ld_last || cnt_max) begin
                state_d = RUN;
            end
            if (!ld.ld_last && cnt_max) begin
                ld_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT_LOAD ? LOAD : RUN;
            cnt_q     <= '0;
            oor_err_q <= 1'b0;
            ld_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oor_err_q <= oor_err_d;
            ld_ovf_q  <= ld_ovf_d;
        end
    end

    // Bank port mux: loader owns it in LOAD, CPU in RUN.
    // Writes on a reset edge are dropped; rdata is forced to 0 in LOAD,
    // on reset and on out-of-range requests.
    always_comb begin
        if (in_load) begin
            b_en    = ~reset & ld_fire;
            b_we    = 4'hf;
            b_idx   = cnt_q;
            b_wdata = ld.ld_data;
        end else begin
            b_en    = ~reset & cpu_req & in_range;
            b_we    = cpu.inst_sram_wen;
            b_idx   = off[DEPTH_LOG2+1:2];
            b_wdata = cpu.inst_sram_wdata;
        end
        b_clr = reset | in_load | (cpu_req & ~in_range);
    end

    sram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (b_en),
        .we    (b_we),
        .idx   (b_idx),
        .wdata (b_wdata),
        .clr   (b_clr),
        .rdata (cpu.inst_sram_rdata)
    );

    assign ld.ld_ready = in_load;
    assign boot_done   = ~in_load;
    assign oor_err     = oor_err_q;
    assign ld_ovf      = ld_ovf_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder: boot load, read-first write,
// range checks, load overflow (small instance), reset mid-load, hold.
module tb_inst_sram_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    inst_sram_if cpu_m ();
    boot_ld_if   ld_m ();
    inst_sram_if cpu_s ();
    boot_ld_if   ld_s ();

    logic done_m, oor_m, ovf_m;
    logic done_s, oor_s, ovf_s;

    inst_sram_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_m),
        .ld        (ld_m),
        .boot_done (done_m),
        .oor_err   (oor_m),
        .ld_ovf    (ovf_m)
    );

    inst_sram_responder #(.DEPTH_LOG2(2)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_s),
        .ld        (ld_s),
        .boot_done (done_s),
        .oor_err   (oor_s),
        .ld_ovf    (ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_m(input logic [31:0] a);
        cpu_m.inst_sram_en   = 1'b1;
        cpu_m.inst_sram_wen  = 4'h0;
        cpu_m.inst_sram_addr = a;
    endtask

    task automatic wr_m(input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d);
        cpu_m.inst_sram_en    = 1'b1;
        cpu_m.inst_sram_wen   = w;
        cpu_m.inst_sram_addr  = a;
        cpu_m.inst_sram_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        cpu_m.inst_sram_en = 0; cpu_m.inst_sram_wen = 0;
        cpu_m.inst_sram_addr = 0; cpu_m.inst_sram_wdata = 0;
        cpu_s.inst_sram_en = 0; cpu_s.inst_sram_wen = 0;
        cpu_s.inst_sram_addr = 0; cpu_s.inst_sram_wdata = 0;
        ld_m.ld_valid = 0; ld_m.ld_data = 0; ld_m.ld_last = 0;
        ld_s.ld_valid = 0; ld_s.ld_data = 0; ld_s.ld_last = 0;
        tick(); tick();
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_ready", 32'(ld_m.ld_ready), 32'd1);
        chk("rst_rdata", cpu_m.inst_sram_rdata, 32'd0);
        chk("rst_oor", 32'(oor_m), 32'd0);
        chk("rst_ovf", 32'(ovf_m), 32'd0);
        reset = 1'b0;

        // Load overflow on the 4-word instance: words 1..5, no last.
        ld_s.ld_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_s.ld_data = i;
            tick();
        end
        chk("ovf_pre", 32'(ovf_s), 32'd0);
        chk("ovf_pre_rdy", 32'(ld_s.ld_ready), 32'd1);
        ld_s.ld_data = 4;
        tick();
        chk("ovf_flag", 32'(ovf_s), 32'd1);
        chk("ovf_rdy", 32'(ld_s.ld_ready), 32'd0);
        chk("ovf_done", 32'(done_s), 32'd1);
        ld_s.ld_data = 5;
        tick();
        chk("ovf_pending", 32'(ld_s.ld_ready), 32'd0);
        ld_s.ld_valid = 1'b0;
        cpu_s.inst_sram_en = 1'b1;
        cpu_s.inst_sram_addr = 32'h1c00_000c;
        tick();
        chk("ovf_w3", cpu_s.inst_sram_rdata, 32'd4);
        cpu_s.inst_sram_addr = 32'h1c00_0000;
        tick();
        chk("ovf_w0", cpu_s.inst_sram_rdata, 32'd1);
        cpu_s.inst_sram_addr = 32'h1c00_0010;
        tick();
        chk("ovf_oor_rd", cpu_s.inst_sram_rdata, 32'd0);
        chk("ovf_oor", 32'(oor_s), 32'd1);
        cpu_s.inst_sram_en = 1'b0;

        // Boot load on the main instance.
        ld_m.ld_valid = 1'b1;
        ld_m.ld_data = 32'h11; tick();
        ld_m.ld_data = 32'h22; tick();
        chk("ld_done_mid", 32'(done_m), 32'd0);
        ld_m.ld_data = 32'h33; ld_m.ld_last = 1'b1; tick();
        ld_m.ld_valid = 1'b0; ld_m.ld_last = 1'b0;
        chk("ld_done", 32'(done_m), 32'd1);
        chk("ld_rdy_run", 32'(ld_m.ld_ready), 32'd0);
        chk("ld_rdata0", cpu_m.inst_sram_rdata, 32'd0);

        rd_m(32'h1c00_0008); tick();
        chk("rd_08", cpu_m.inst_sram_rdata, 32'h33);
        // Back-to-back then hold.
        rd_m(32'h1c00_0000); tick();
        chk("rd_00", cpu_m.inst_sram_rdata, 32'h11);
        rd_m(32'h1c00_0004); tick();
        chk("rd_04", cpu_m.inst_sram_rdata, 32'h22);
        cpu_m.inst_sram_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold", cpu_m.inst_sram_rdata, 32'h22);
        end

        // Read-first partial write, then read back new word.
        wr_m(32'h1c00_0004, 4'b0011, 32'hAABB_CCDD); tick();
        chk("wr_old", cpu_m.inst_sram_rdata, 32'h22);
        rd_m(32'h1c00_0004); tick();
        chk("wr_new", cpu_m.inst_sram_rdata, 32'h0000_CCDD);

        // Last word of the window, unaligned address bits ignored.
        wr_m(32'h1c00_3ffc, 4'hf, 32'hDEAD_BEEF); tick();
        rd_m(32'h1c00_3fff); tick();
        chk("top_word", cpu_m.inst_sram_rdata, 32'hDEAD_BEEF);
        chk("top_no_oor", 32'(oor_m), 32'd0);

        // Out of range above and below the window.
        rd_m(32'h1c00_4000); tick();
        chk("oor_hi_rd", cpu_m.inst_sram_rdata, 32'd0);
        chk("oor_hi", 32'(oor_m), 32'd1);
        rd_m(32'h1c00_0000); tick();
        chk("oor_mid_rd", cpu_m.inst_sram_rdata, 32'h11);
        chk("oor_sticky", 32'(oor_m), 32'd1);
        wr_m(32'h1bff_fffc, 4'hf, 32'h1234_5678); tick();
        chk("oor_lo_rd", cpu_m.inst_sram_rdata, 32'd0);
        chk("oor_lo", 32'(oor_m), 32'd1);

        // Reset in RUN with a write on the reset edge (dropped).
        wr_m(32'h1c00_0008, 4'hf, 32'h9999_9999);
        reset = 1'b1; tick();
        cpu_m.inst_sram_en = 1'b0;
        chk("rrun_rdata", cpu_m.inst_sram_rdata, 32'd0);
        chk("rrun_done", 32'(done_m), 32'd0);
        reset = 1'b0;

        // Partial load, reset, reload.
        ld_m.ld_valid = 1'b1;
        ld_m.ld_data = 32'hA1; tick();
        ld_m.ld_data = 32'hA2; tick();
        ld_m.ld_valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rml_oor", 32'(oor_m), 32'd0);
        chk("rml_ovf", 32'(ovf_m), 32'd0);
        ld_m.ld_valid = 1'b1;
        ld_m.ld_data = 32'h55; tick();
        ld_m.ld_data = 32'h66; ld_m.ld_last = 1'b1; tick();
        ld_m.ld_valid = 1'b0; ld_m.ld_last = 1'b0;
        chk("rml_done", 32'(done_m), 32'd1);
        rd_m(32'h1c00_0000); tick();
        chk("rml_w0", cpu_m.inst_sram_rdata, 32'h55);
        rd_m(32'h1c00_0004); tick();
        chk("rml_w1", cpu_m.inst_sram_rdata, 32'h66);
        rd_m(32'h1c00_0008); tick();
        chk("rml_w2_kept", cpu_m.inst_sram_rdata, 32'h33);
        chk("rml_oor_end", 32'(oor_m), 32'd0);
        cpu_m.inst_sram_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Responder end of the instruction-SRAM interface driven by the fetch stage: accepts `en/wen/addr/wdata` and returns `rdata` with fixed one-cycle latency. It also contains a boot loader: after reset it fills memory from a valid/ready word stream before it serves the CPU. The block sits between the CPU core's inst-SRAM port and the SoC top. It replaces the behavioural RAM used in simulation, and boot image load becomes part of the design.

## Interface
- `DEPTH_LOG2`, default 12: memory depth is 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h1c00_0000: byte address of word 0; it matches the core's reset PC.
- `BOOT_LOAD`, default 1: 1 means the block leaves reset in LOAD; 0 means it leaves reset in RUN.
- `clk  in  1`: clock, `clk`.
- `reset  in  1`: reset, `reset`, synchronous, active-high.
- `inst_sram_en  in  1`: access request for the current cycle.
- `inst_sram_wen  in  4`: byte write enables; 0 means read.
- `inst_sram_addr  in  32`: byte address.
- `inst_sram_wdata  in  32`: write data.
- `inst_sram_rdata  out  32`: read data, registered.
- `ld_valid  in  1`: boot word valid.
- `ld_data  in  32`: boot word.
- `ld_last  in  1`: final boot word.
- `ld_ready  out  1`: loader can accept a word.
- `boot_done  out  1`: high in RUN; the SoC holds the core in reset while it is low.
- `oor_err  out  1`: sticky; set by a CPU access outside the memory window.
- `ld_ovf  out  1`: sticky; set when the load stream filled memory without `ld_last`.

## Operation
- States:
  - LOAD: `ld_ready`=1 and `boot_done`=0. CPU requests are ignored.
  - RUN: `ld_ready`=0 and `boot_done`=1.
- Reset puts the block in LOAD if BOOT_LOAD=1, else RUN.
  - Load counter resets to 0; `rdata`, `oor_err` and `ld_ovf` reset to 0.
  - Memory contents are not cleared.
- LOAD:
  - Each cycle with `ld_valid & ld_ready` writes `ld_data` to word[cnt] and increments `cnt`.
  - `ld_last` accepted: go to RUN.
  - Accepting a word at `cnt` = DEPTH-1 without `ld_last`: go to RUN and set `ld_ovf`. `cnt` does not wrap. Further words are refused because `ld_ready`=0.
- RUN, address decode:
  - off = addr − BASE_ADDR, 32-bit wrap arithmetic.
  - Index = off[DEPTH_LOG2+1:2]. addr[1:0] is ignored; alignment faults are the core's job.
  - In range means off < 4·2^DEPTH_LOG2, unsigned compare.
- RUN, read (`en`=1, `wen`=0): next `rdata` = word[index].
- RUN, write (`en`=1, `wen`≠0): each byte lane i with `wen[i]`=1 is written. `rdata` still returns the old word (read-first).
- RUN, out of range with `en`=1: no write, next `rdata`=0, `oor_err` set.
- `en`=0: `rdata` holds its previous value.
- `rdata` in LOAD: 0.

## Timing
- Request sampled at posedge N; `rdata` valid from just after N until posedge N+1. This matches a fetch stage that issues `nextpc` and latches the instruction one edge later.
- Back-to-back requests are accepted every cycle; there is no stall or backpressure on the CPU side.
- Write to address A at edge N, then read of A at edge N+1: returns the new data.
- The LOAD→RUN transition takes effect on the edge that accepts the final word. `boot_done` is 1 in the following cycle, and the first CPU access is possible at the next edge.
- The loader writes at most one word per cycle; `ld_ready` is combinational from state only.
- Reset asserted mid-LOAD: `cnt` returns to 0 and the load restarts from word 0. Already-written words are overwritten by the new stream.
- Reset asserted in RUN: `rdata`=0 on the next cycle; a write sampled on the reset edge is dropped.

## Structure
- Shared package holds:
  - state enum {LOAD, RUN};
  - BASE_ADDR default 32'h1c00_0000, which shares its definition with the core's reset-PC constant;
  - the one-bit rdata latency constant.
- Sub-module `sram_bank`:
  - single-port synchronous RAM, 2^DEPTH_LOG2 × 32;
  - 4 byte-lane write enables, read-first, registered output with hold-on-idle.
- The top level muxes the loader and CPU onto `sram_bank` by state. It also holds the decode/range check, the counter, the FSM and the sticky flags.

## Test plan
- **Boot load:** reset, then stream 0x11,0x22,0x33 with `ld_last` on the third word → `boot_done`=1 the cycle after. Reads at 0x1c000000/04/08 return 0x11/0x22/0x33, one cycle after `en`.
- **Read-first write:** RUN, write `wen`=4'b0011, wdata 0xAABBCCDD to 0x1c000004 (old 0x22) → `rdata`=0x22. The next read returns 0x0000CCDD.
- **Out of range:** with DEPTH_LOG2=12, read 0x1c004000 and 0x1bfffffc → `rdata`=0 for each, and `oor_err` rises after the first and stays 1.
- **Load overflow:** DEPTH_LOG2=2, stream 5 words without `ld_last` → 4 accepted, `ld_ovf`=1, `ld_ready`=0, and the fifth word stays pending.
- **Reset mid-load:** reset after 2 of 4 words, then reload 0x55,0x66 with last → word0=0x55, word1=0x66. `oor_err` and `ld_ovf` are 0.
- **Hold and back-to-back:** reads to 0x1c000000 and 0x1c000004 on consecutive cycles, then `en`=0 for 3 cycles → `rdata` follows with one-cycle lag, then holds the last value.
